// File: rtl/sw_seq_feeder_if.sv
// Bundle for the packed-byte input stream, the per-base stream toward the
// Smith-Waterman aligner, and the feeder's status outputs.
interface sw_seq_feeder_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        sw_valid;
    logic [1:0]  sw_data_ref;
    logic [1:0]  sw_data_query;
    logic        sw_finish;
    logic        busy;
    logic [15:0] pairs_done;

    // master is the surrounding system, slave is the feeder itself
    modport master (
        output in_valid, in_data, sw_finish,
        input  in_ready, sw_valid, sw_data_ref, sw_data_query, busy, pairs_done
    );

    modport slave (
        input  in_valid, in_data, sw_finish,
        output in_ready, sw_valid, sw_data_ref, sw_data_query, busy, pairs_done
    );
endinterface

// File: rtl/sw_seq_feeder.sv
// Collects one reference/query pair from a packed 2-bit-base byte stream and
// replays it base-by-base to the aligner, then waits for the aligner to finish.
module sw_seq_feeder #(
    parameter int REF_LEN = 64,
    parameter int QRY_LEN = 48
) (
    input logic            clk,
    input logic            reset,
    sw_seq_feeder_if.slave bus
);

    localparam int REF_BITS    = 2 * REF_LEN;
    localparam int QRY_BITS    = 2 * QRY_LEN;
    localparam int TOTAL_BYTES = (REF_LEN + QRY_LEN) / 4;
    localparam int BYTE_W      = $clog2(TOTAL_BYTES);
    localparam int BASE_W      = $clog2(REF_LEN);

    localparam logic [BYTE_W-1:0] REF_BYTES = BYTE_W'(REF_LEN / 4);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(TOTAL_BYTES - 1);
    localparam logic [BASE_W-1:0] LAST_BASE = BASE_W'(REF_LEN - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] SEND = 3'd2;
    localparam logic [2:0] GAP  = 3'd3;
    localparam logic [2:0] WAIT = 3'd4;

    if (QRY_LEN > REF_LEN || QRY_LEN < 4 || (REF_LEN % 4) != 0 || (QRY_LEN % 4) != 0) begin : g_bad_params
        $error("sw_seq_feeder: lengths must be multiples of 4 with 4 <= QRY_LEN <= REF_LEN");
    end

    logic [2:0]          state_q, state_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [BASE_W-1:0]   base_cnt_q, base_cnt_d;
    logic [REF_BITS-1:0] ref_q, ref_d, ref_shift;
    logic [QRY_BITS-1:0] qry_q, qry_d, qry_shift;
    logic                sw_valid_q, sw_valid_d;
    logic [1:0]          sw_ref_q, sw_ref_d;
    logic [1:0]          sw_qry_q, sw_qry_d;
    logic                busy_q, busy_d;
    logic [15:0]         pairs_done_q, pairs_done_d;

    // Bytes shift in from the top so byte 0 ends up at the bottom; during SEND
    // the vectors shift right by one base, so the query runs out into zeros.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        base_cnt_d   = base_cnt_q;
        ref_d        = ref_q;
        qry_d        = qry_q;
        pairs_done_d = pairs_done_q;
        sw_valid_d   = 1'b0;
        sw_ref_d     = 2'b00;
        sw_qry_d     = 2'b00;
        ref_shift    = (ref_q >> 8) | (REF_BITS'(bus.in_data) << (REF_BITS - 8));
        qry_shift    = (qry_q >> 8) | (QRY_BITS'(bus.in_data) << (QRY_BITS - 8));

        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (bus.in_valid) begin
                    if (byte_cnt_q < REF_BYTES) begin
                        ref_d = ref_shift;
                    end else begin
                        qry_d = qry_shift;
                    end
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        base_cnt_d = '0;
                        state_d    = SEND;
                        sw_valid_d = 1'b1;
                        sw_ref_d   = ref_q[1:0];
                        sw_qry_d   = qry_shift[1:0];
                        ref_d      = ref_q >> 2;
                        qry_d      = qry_shift >> 2;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            SEND: begin
                if (base_cnt_q == LAST_BASE) begin
                    base_cnt_d = '0;
                    state_d    = GAP;
                end else begin
                    base_cnt_d = base_cnt_q + 1'b1;
                    sw_valid_d = 1'b1;
                    sw_ref_d   = ref_q[1:0];
                    sw_qry_d   = qry_q[1:0];
                    ref_d      = ref_q >> 2;
                    qry_d      = qry_q >> 2;
                end
            end
            GAP:  state_d = WAIT;
            WAIT: begin
                if (bus.sw_finish) begin
                    state_d      = LOAD;
                    pairs_done_d = pairs_done_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SEND) || (state_d == GAP) || (state_d == WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            base_cnt_q   <= '0;
            sw_valid_q   <= 1'b0;
            sw_ref_q     <= 2'b00;
            sw_qry_q     <= 2'b00;
            busy_q       <= 1'b0;
            pairs_done_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            base_cnt_q   <= base_cnt_d;
            sw_valid_q   <= sw_valid_d;
            sw_ref_q     <= sw_ref_d;
            sw_qry_q     <= sw_qry_d;
            busy_q       <= busy_d;
            pairs_done_q <= pairs_done_d;
        end
    end

    // Base storage is fully rewritten by every LOAD, so it carries no reset.
    always_ff @(posedge clk) begin
        ref_q <= ref_d;
        qry_q <= qry_d;
    end

    assign bus.in_ready      = (state_q == LOAD);
    assign bus.sw_valid      = sw_valid_q;
    assign bus.sw_data_ref   = sw_ref_q;
    assign bus.sw_data_query = sw_qry_q;
    assign bus.busy          = busy_q;
    assign bus.pairs_done    = pairs_done_q;

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Scoreboard bench for sw_seq_feeder: expected bases are queued when a pair is
// loaded and compared by a monitor as the feeder streams them out.
module tb_sw_seq_feeder;

    localparam int REF_LEN     = 64;
    localparam int QRY_LEN     = 48;
    localparam int REF_BYTES   = REF_LEN / 4;
    localparam int TOTAL_BYTES = (REF_LEN + QRY_LEN) / 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    sw_seq_feeder_if bus ();

    sw_seq_feeder #(.REF_LEN(REF_LEN), .QRY_LEN(QRY_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  exp_q[$];
    logic [15:0] exp_pairs = 16'd0;
    int          run_len = 0;
    logic        prev_valid = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Monitor: every valid base is popped from the scoreboard; idle cycles must be quiet
    always @(negedge clk) begin
        if (reset) begin
            run_len    = 0;
            prev_valid = 1'b0;
        end else begin
            if (bus.sw_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_base", 32'd1, 32'd0);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    checkOutput("sw_data_ref", 32'(bus.sw_data_ref), 32'(e[3:2]));
                    checkOutput("sw_data_query", 32'(bus.sw_data_query), 32'(e[1:0]));
                end
                run_len++;
            end else begin
                checkOutput("idle_data", 32'({bus.sw_data_ref, bus.sw_data_query}), 32'd0);
                if (prev_valid) checkOutput("stream_len", 32'(run_len), 32'(REF_LEN));
                run_len = 0;
            end
            prev_valid = bus.sw_valid;
        end
    end

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.sw_finish = 1'b0;
        exp_q.delete();
        exp_pairs = 16'd0;
        #1;
        checkOutput("rst_sw_valid", 32'(bus.sw_valid), 32'd0);
        checkOutput("rst_data", 32'({bus.sw_data_ref, bus.sw_data_query}), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_pairs_done", 32'(bus.pairs_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        checkOutput("load_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // Loads one pair (random or fixed 0xE4/0x1B), optionally with in_valid gaps
    // and an sw_finish pulse mid-load; returns on the first SEND cycle.
    task automatic applyStimulus(input bit random_data, input bit toggle, input bit finish_in_load);
        logic [7:0] pb[TOTAL_BYTES];
        logic [7:0] b;
        int         sent = 0;
        int         cyc = 0;
        for (int i = 0; i < TOTAL_BYTES; i++) begin
            if (random_data) pb[i] = 8'($urandom_range(0, 255));
            else             pb[i] = (i < REF_BYTES) ? 8'hE4 : 8'h1B;
        end
        for (int k = 0; k < REF_LEN; k++) begin
            logic [1:0] r, q;
            b = pb[k / 4];
            r = 2'((b >> (2 * (k % 4))) & 8'h03);
            if (k < QRY_LEN) begin
                b = pb[REF_BYTES + k / 4];
                q = 2'((b >> (2 * (k % 4))) & 8'h03);
            end else begin
                q = 2'b00;
            end
            exp_q.push_back({r, q});
        end
        while (sent < TOTAL_BYTES && cyc < 400) begin
            bus.in_valid  = toggle ? ((cyc % 2) == 0) : 1'b1;
            bus.in_data   = bus.in_valid ? pb[sent] : 8'($urandom_range(0, 255));
            bus.sw_finish = finish_in_load && (cyc == 10);
            checkOutput("in_ready_load", 32'(bus.in_ready), 32'd1);
            checkOutput("sw_valid_load", 32'(bus.sw_valid), 32'd0);
            @(posedge clk);
            if (bus.in_valid && bus.in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        if (sent < TOTAL_BYTES) checkOutput("load_timeout", 32'(sent), 32'(TOTAL_BYTES));
        bus.sw_finish = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'($urandom_range(0, 255));
        checkOutput("send_start_valid", 32'(bus.sw_valid), 32'd1);
        checkOutput("send_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("send_busy", 32'(bus.busy), 32'd1);
    endtask

    // Runs from the first SEND cycle to the first WAIT cycle
    task automatic wait_stream_end(input bit finish_in_send);
        int cyc = 0;
        while (bus.sw_valid && cyc < 300) begin
            bus.sw_finish = finish_in_send && (cyc == 10);
            bus.in_data   = 8'($urandom_range(0, 255));
            @(negedge clk);
            cyc++;
        end
        bus.sw_finish = 1'b0;
        if (cyc >= 300) checkOutput("stream_timeout", 32'd0, 32'd1);
        checkOutput("gap_busy", 32'(bus.busy), 32'd1);
        checkOutput("gap_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        checkOutput("wait_busy", 32'(bus.busy), 32'd1);
        checkOutput("wait_sw_valid", 32'(bus.sw_valid), 32'd0);
        checkOutput("wait_pairs_done", 32'(bus.pairs_done), 32'(exp_pairs));
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic finish_pair();
        bus.in_valid  = 1'b0;
        bus.sw_finish = 1'b1;
        @(negedge clk);
        bus.sw_finish = 1'b0;
        exp_pairs     = exp_pairs + 16'd1;
        checkOutput("pairs_done", 32'(bus.pairs_done), 32'(exp_pairs));
        checkOutput("after_finish_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("after_finish_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        do_reset();

        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_stream_end(1'b0);
        repeat (5000) @(negedge clk);
        checkOutput("long_wait_busy", 32'(bus.busy), 32'd1);
        checkOutput("long_wait_in_ready", 32'(bus.in_ready), 32'd0);
        finish_pair();

        applyStimulus(1'b0, 1'b1, 1'b1);
        wait_stream_end(1'b1);
        finish_pair();

        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_stream_end(1'b0);
        finish_pair();

        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_sw_valid", 32'(bus.sw_valid), 32'd0);
        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_stream_end(1'b0);
        finish_pair();

        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_stream_end(1'b0);
        force dut.pairs_done_d = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.pairs_done_d;
        exp_pairs = 16'hFFFF;
        @(negedge clk);
        checkOutput("pairs_done_preset", 32'(bus.pairs_done), 32'(exp_pairs));
        finish_pair();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
